instr_fetch_unit: RTL and testbench

Fetch stage of the RISC pipeline. Holds the program counter, issues one-outstanding requests to a variable-latency instruction memory, and loads the IF/ID pipeline register. That register's opcode field drives the control unit directly. The stage also handles branch redirects (flush plus discard of in-flight responses) and stalls from the hazard logic via a one-entry skid buffer.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/if_id_reg.sv | 65 ++++++
 rtl/instr_fetch_unit.sv | 76 +++++++
 tb/tb_instr_fetch_unit.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode field layout and the
// opcode encodings the control unit decodes.
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} fetch_state_e;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 13;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_W-1:0] OP_RTYPE   = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_LOAD    = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_STORE   = 3'b101;
  localparam logic [OPCODE_W-1:0] OP_BRANCH  = 3'b110;
  localparam logic [OPCODE_W-1:0] OP_IMM     = 3'b111;
  localparam logic [OPCODE_W-1:0] OP_IMM_ALT = 3'b001;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with a one-entry skid that catches a response
// arriving while ID is stalled on a live instruction.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int IW = 16,
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_flush,
  input  logic          i_rsp_vld,
  input  logic [IW-1:0] i_rsp_instr,
  input  logic [AW-1:0] i_rsp_pc,
  output logic [IW-1:0] o_instr,
  output logic [AW-1:0] o_pc,
  output logic          o_valid,
  output logic          o_skid_vld
);
  logic [IW-1:0] r_instr, r_skid_instr;
  logic [AW-1:0] r_pc, r_skid_pc;
  logic          r_valid, r_skid_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr      <= '0;
      r_pc         <= '0;
      r_valid      <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_vld   <= 1'b0;
    end else if (i_flush) begin
      r_valid    <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (i_load) begin
      if (r_skid_vld) begin
        // Skid is older than any same-cycle response, so it goes first.
        r_instr    <= r_skid_instr;
        r_pc       <= r_skid_pc;
        r_valid    <= 1'b1;
        r_skid_vld <= i_rsp_vld;
        if (i_rsp_vld) begin
          r_skid_instr <= i_rsp_instr;
          r_skid_pc    <= i_rsp_pc;
        end
      end else if (i_rsp_vld) begin
        r_instr <= i_rsp_instr;
        r_pc    <= i_rsp_pc;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end else if (i_rsp_vld) begin
      r_skid_instr <= i_rsp_instr;
      r_skid_pc    <= i_rsp_pc;
      r_skid_vld   <= 1'b1;
    end
  end

  assign o_instr    = r_instr;
  assign o_pc       = r_pc;
  assign o_valid    = r_valid;
  assign o_skid_vld = r_skid_vld;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, single-outstanding imem request FSM, branch redirect with
// in-flight discard, feeding the IF/ID register.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int            IW       = 16,
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                ImemReq,
  output logic [AW-1:0]       ImemAddr,
  input  logic [IW-1:0]       ImemRdata,
  input  logic                ImemValid,
  input  logic                Stall,
  input  logic                BranchTaken,
  input  logic [AW-1:0]       BranchTarget,
  output logic [IW-1:0]       InstrOut,
  output logic [AW-1:0]       PcOut,
  output logic                ValidOut,
  output logic [OPCODE_W-1:0] OpCode
);
  fetch_state_e  r_state, w_nxt_state;
  logic [AW-1:0] r_pc, r_req_pc, w_nxt_pc;
  logic          w_issue, w_rsp_vld, w_load, w_skid_vld;

  assign w_issue   = (r_state == REQ) && !w_skid_vld;
  assign w_rsp_vld = (r_state == WAIT) && ImemValid && !BranchTaken;
  assign w_load    = !ValidOut || !Stall;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_pc    = r_pc;
    case (r_state)
      IDLE:  w_nxt_state = REQ;
      REQ:   if (w_issue) w_nxt_state = BranchTaken ? DRAIN : WAIT;
      WAIT:  if (ImemValid) w_nxt_state = REQ;
             else if (BranchTaken) w_nxt_state = DRAIN;
      DRAIN: if (ImemValid) w_nxt_state = REQ;
      default: w_nxt_state = IDLE;
    endcase
    if (BranchTaken)  w_nxt_pc = BranchTarget;
    else if (w_issue) w_nxt_pc = r_pc + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_req_pc <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_pc    <= w_nxt_pc;
      if (w_issue) r_req_pc <= r_pc;
    end
  end

  if_id_reg #(.IW(IW), .AW(AW)) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_load),
    .i_flush     (BranchTaken),
    .i_rsp_vld   (w_rsp_vld),
    .i_rsp_instr (ImemRdata),
    .i_rsp_pc    (r_req_pc),
    .o_instr     (InstrOut),
    .o_pc        (PcOut),
    .o_valid     (ValidOut),
    .o_skid_vld  (w_skid_vld)
  );

  assign ImemReq  = w_issue;
  assign ImemAddr = r_pc;
  assign OpCode   = InstrOut[IW-1 -: OPCODE_W];
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: variable-latency memory model, expected
// instruction stream scoreboard, directed corner cases plus random stall/branch.
module tb_instr_fetch_unit;
  localparam logic [15:0] RPC = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ImemReq, ImemValid, Stall, BranchTaken, ValidOut;
  logic [15:0] ImemAddr, ImemRdata, BranchTarget, InstrOut, PcOut;
  logic [2:0]  OpCode;

  instr_fetch_unit #(.IW(16), .AW(16), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemRdata(ImemRdata), .ImemValid(ImemValid), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .InstrOut(InstrOut),
    .PcOut(PcOut), .ValidOut(ValidOut), .OpCode(OpCode)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, n_acc = 0;
  int lat_mode = 1;
  int epoch = 0;
  logic [15:0] exp_q[$];
  logic [15:0] nxt_pc = RPC;

  function automatic logic [15:0] memf(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    @(negedge clk);
    while (!ImemReq && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ImemReq) chk(nm, 32'(ImemReq), 32'd1);
  endtask

  // Instruction memory: answers each request after L cycles unless a reset
  // intervened while it was outstanding.
  initial begin
    logic [15:0] a;
    int l, ep;
    ImemValid = 1'b0;
    ImemRdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && ImemReq) begin
        a  = ImemAddr;
        ep = epoch;
        l  = (lat_mode != 0) ? lat_mode : int'($urandom_range(1, 4));
        repeat (l) @(posedge clk);
        #1;
        if (ep == epoch && rst_n) begin
          ImemValid = 1'b1;
          ImemRdata = memf(a);
          @(posedge clk);
          #1 ImemValid = 1'b0;
        end
      end
    end
  end

  // Scoreboard: ID sees consecutive addresses from reset/branch target on,
  // each exactly once, with the memory contents of that address.
  initial begin
    logic [15:0] e, ed;
    int idle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        nxt_pc = RPC;
        idle   = 0;
      end else begin
        if (ValidOut && !Stall) begin
          if (exp_q.size() == 0) begin
            exp_q.push_back(nxt_pc);
            nxt_pc = nxt_pc + 16'd1;
          end
          e  = exp_q.pop_front();
          ed = memf(e);
          chk("sb_pc", 32'(PcOut), 32'(e));
          chk("sb_instr", 32'(InstrOut), 32'(ed));
          chk("sb_opcode", 32'(OpCode), 32'(ed[15:13]));
          n_acc++;
          idle = 0;
        end else begin
          idle++;
          if (idle == 200) chk("sb_progress", 32'(idle), 32'd0);
        end
        if (BranchTaken) begin
          exp_q.delete();
          nxt_pc = BranchTarget;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: sim time %0t exceeded limit", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    rst_n = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = '0;
    @(posedge clk); #1;
    chk("rst_req", 32'(ImemReq), 0);
    chk("rst_valid", 32'(ValidOut), 0);
    chk("rst_pcout", 32'(PcOut), 0);
    chk("rst_instr", 32'(InstrOut), 0);
    chk("rst_opcode", 32'(OpCode), 0);
    chk("rst_addr", 32'(ImemAddr), 32'(RPC));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk) chk("c0_noreq", 32'(ImemReq), 0);
    @(negedge clk) chk("c1_req", 32'(ImemReq), 1);
    chk("c1_addr", 32'(ImemAddr), 32'h10);
    @(negedge clk) chk("c2_noreq", 32'(ImemReq), 0);
    @(negedge clk) chk("c3_valid", 32'(ValidOut), 1);
    chk("c3_pcout", 32'(PcOut), 32'h10);
    chk("c3_addr", 32'(ImemAddr), 32'h11);

    // Stall with IF/ID full: the next response lands in the skid
    @(posedge clk); #1 Stall = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("stall_noreq", 32'(ImemReq), 0);
    chk("stall_valid", 32'(ValidOut), 1);
    chk("stall_pc", 32'(PcOut), 32'h11);
    @(posedge clk); #1 Stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("skid_pc", 32'(PcOut), 32'h12);
    chk("skid_valid", 32'(ValidOut), 1);

    // Branch while waiting on a 3-cycle response
    lat_mode = 3;
    wait_req("brw_req0");
    @(posedge clk); #1 BranchTaken = 1'b1; BranchTarget = 16'h0040;
    @(posedge clk); #1 BranchTaken = 1'b0;
    @(negedge clk) chk("brw_flush", 32'(ValidOut), 0);
    wait_req("brw_req1");
    chk("brw_addr", 32'(ImemAddr), 32'h40);

    // Branch coinciding with the response
    lat_mode = 2;
    wait_req("brv_req0");
    @(posedge clk); #1;
    @(posedge clk); #1 BranchTaken = 1'b1; BranchTarget = 16'h0080;
    @(posedge clk); #1 BranchTaken = 1'b0;
    @(negedge clk);
    chk("brv_req", 32'(ImemReq), 1);
    chk("brv_addr", 32'(ImemAddr), 32'h80);

    // PC wrap
    lat_mode = 1;
    @(posedge clk); #1 BranchTaken = 1'b1; BranchTarget = 16'hFFFE;
    @(posedge clk); #1 BranchTaken = 1'b0;
    k = 0;
    do begin
      wait_req("wrap_req");
      k++;
    end while (ImemAddr != 16'hFFFF && k < 20);
    chk("wrap_pre", 32'(ImemAddr), 32'hFFFF);
    @(posedge clk);
    wait_req("wrap_req2");
    chk("wrap_addr", 32'(ImemAddr), 32'h0000);

    // Random stall/branch traffic with random latency
    lat_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      Stall = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 24) == 0) begin
        BranchTaken  = 1'b1;
        BranchTarget = 16'($urandom);
      end else begin
        BranchTaken = 1'b0;
      end
    end
    @(posedge clk); #1 Stall = 1'b0; BranchTaken = 1'b0;

    // Reset while a request is outstanding
    lat_mode = 3;
    wait_req("rstw_req");
    @(posedge clk); #1;
    epoch++;
    rst_n = 1'b0;
    #1;
    chk("rstw_req", 32'(ImemReq), 0);
    chk("rstw_valid", 32'(ValidOut), 0);
    chk("rstw_pcout", 32'(PcOut), 0);
    chk("rstw_instr", 32'(InstrOut), 0);
    chk("rstw_opcode", 32'(OpCode), 0);
    chk("rstw_addr", 32'(ImemAddr), 32'(RPC));
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b1;
    lat_mode = 1;
    wait_req("rstw_req1");
    chk("rstw_restart", 32'(ImemAddr), 32'(RPC));

    lat_mode = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      Stall = ($urandom_range(0, 9) < 3);
      BranchTaken = ($urandom_range(0, 29) == 0);
      BranchTarget = 16'($urandom);
    end
    @(posedge clk); #1 Stall = 1'b0; BranchTaken = 1'b0;
    repeat (20) @(posedge clk);
    chk("accepted_enough", 32'(n_acc > 300), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
